// File: rtl/fp_mult_arbiter_if.sv
// Requester, multiplier and response signals of the shared FP multiplier arbiter.
// The arbiter connects through the slave modport; clients and the multiplier use master.
interface fp_mult_arbiter_if #(
    parameter int pWidth = 64,
    parameter int pReq   = 4
);
    logic [pReq-1:0]        iv_ReqValid;
    logic [pReq*pWidth-1:0] iv_ReqA;
    logic [pReq*pWidth-1:0] iv_ReqB;
    logic [pReq-1:0]        ov_ReqReady;
    logic [pWidth-1:0]      ov_MulA;
    logic [pWidth-1:0]      ov_MulB;
    logic                   o_MulDv;
    logic                   o_MulClkEn;
    logic [pWidth-1:0]      iv_MulResult;
    logic                   i_MulOverflow;
    logic                   i_MulUnderflow;
    logic                   i_MulNAN;
    logic [pReq-1:0]        ov_RspValid;
    logic [pWidth-1:0]      ov_RspResult;
    logic [2:0]             ov_RspFlags;
    logic                   o_Idle;

    modport slave (
        input  iv_ReqValid, iv_ReqA, iv_ReqB,
        input  iv_MulResult, i_MulOverflow, i_MulUnderflow, i_MulNAN,
        output ov_ReqReady, ov_MulA, ov_MulB, o_MulDv, o_MulClkEn,
        output ov_RspValid, ov_RspResult, ov_RspFlags, o_Idle
    );

    modport master (
        output iv_ReqValid, iv_ReqA, iv_ReqB,
        output iv_MulResult, i_MulOverflow, i_MulUnderflow, i_MulNAN,
        input  ov_ReqReady, ov_MulA, ov_MulB, o_MulDv, o_MulClkEn,
        input  ov_RspValid, ov_RspResult, ov_RspFlags, o_Idle
    );
endinterface

// File: rtl/fp_mult_arbiter.sv
// Round-robin issue scheduler sharing one pipelined FP multiplier among pReq clients.
// A tag delay line matched to the multiplier latency routes each result back to its owner.
module fp_mult_arbiter #(
    parameter int pWidth   = 64,
    parameter int pReq     = 4,
    parameter int pLatency = 5,
    parameter int pMaxOut  = 8
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    fp_mult_arbiter_if.slave     bus
);
    localparam int cIdxW = $clog2(pReq);
    localparam int cCntW = $clog2(pMaxOut + 1);

    logic [cIdxW-1:0]  rPtr;
    logic [cCntW-1:0]  rOutCnt [pReq];
    logic [pReq-1:0]   wElig;
    logic [pReq-1:0]   wGrant;
    logic              wAccept;
    logic [cIdxW-1:0]  wGrantIdx;
    logic [cIdxW-1:0]  wCand;
    int                wCandInt;
    logic [pWidth-1:0] wSelA;
    logic [pWidth-1:0] wSelB;
    logic              rIssValid;
    logic [cIdxW-1:0]  rIssIdx;
    logic [pWidth-1:0] rMulA;
    logic [pWidth-1:0] rMulB;
    logic [pLatency-1:0] rTagValid;
    logic [cIdxW-1:0]  rTagIdx [pLatency];
    logic [pReq-1:0]   wRspHot;
    logic [pReq-1:0]   rRspValid;
    logic [pWidth-1:0] rRspResult;
    logic [2:0]        rRspFlags;
    logic              wIdle;

    // Handshake: a request transfers on a clock edge where ReqValid[k] and ReqReady[k]
    // are both high; ReqReady is the one-hot grant and never rises without ReqValid.
    always_comb begin
        wElig = '0;
        for (int k = 0; k < pReq; k++) begin
            wElig[k] = bus.iv_ReqValid[k] && (rOutCnt[k] < cCntW'(pMaxOut)) && !i_Rst;
        end
    end

    always_comb begin
        wGrant    = '0;
        wGrantIdx = '0;
        wAccept   = 1'b0;
        wCandInt  = 0;
        wCand     = '0;
        for (int off = 0; off < pReq; off++) begin
            wCandInt = int'(rPtr) + off;
            if (wCandInt >= pReq) wCandInt = wCandInt - pReq;
            wCand = cIdxW'(wCandInt);
            if (!wAccept && wElig[wCand]) begin
                wAccept       = 1'b1;
                wGrantIdx     = wCand;
                wGrant[wCand] = 1'b1;
            end
        end
    end

    always_comb begin
        wSelA = '0;
        wSelB = '0;
        for (int k = 0; k < pReq; k++) begin
            if (wGrant[k]) begin
                wSelA = bus.iv_ReqA[k*pWidth +: pWidth];
                wSelB = bus.iv_ReqB[k*pWidth +: pWidth];
            end
        end
    end

    always_comb begin
        wRspHot = '0;
        for (int k = 0; k < pReq; k++) begin
            wRspHot[k] = rTagValid[pLatency-1] && (rTagIdx[pLatency-1] == cIdxW'(k));
        end
    end

    always_comb begin
        wIdle = !rIssValid;
        for (int k = 0; k < pReq; k++) begin
            if (rOutCnt[k] != '0) wIdle = 1'b0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            rPtr       <= '0;
            rIssValid  <= 1'b0;
            rIssIdx    <= '0;
            rMulA      <= '0;
            rMulB      <= '0;
            rTagValid  <= '0;
            rRspValid  <= '0;
            rRspResult <= '0;
            rRspFlags  <= '0;
            for (int i = 0; i < pLatency; i++) rTagIdx[i] <= '0;
            for (int k = 0; k < pReq; k++) rOutCnt[k] <= '0;
        end else begin
            rIssValid <= wAccept;
            if (wAccept) begin
                rPtr    <= (wGrantIdx == cIdxW'(pReq - 1)) ? '0 : wGrantIdx + cIdxW'(1);
                rIssIdx <= wGrantIdx;
                rMulA   <= wSelA;
                rMulB   <= wSelB;
            end
            rTagValid[0] <= rIssValid;
            rTagIdx[0]   <= rIssIdx;
            for (int i = 1; i < pLatency; i++) begin
                rTagValid[i] <= rTagValid[i-1];
                rTagIdx[i]   <= rTagIdx[i-1];
            end
            rRspValid <= wRspHot;
            if (rTagValid[pLatency-1]) begin
                rRspResult <= bus.iv_MulResult;
                rRspFlags  <= {bus.i_MulNAN, bus.i_MulOverflow, bus.i_MulUnderflow};
            end
            // Credit returns one cycle after the response is presented to its owner.
            for (int k = 0; k < pReq; k++) begin
                if (wGrant[k] && !rRspValid[k]) begin
                    rOutCnt[k] <= rOutCnt[k] + cCntW'(1);
                end else if (!wGrant[k] && rRspValid[k] && rOutCnt[k] != '0) begin
                    rOutCnt[k] <= rOutCnt[k] - cCntW'(1);
                end
            end
        end
    end

    assign bus.ov_ReqReady  = wGrant;
    assign bus.ov_MulA      = rMulA;
    assign bus.ov_MulB      = rMulB;
    assign bus.o_MulDv      = rIssValid;
    assign bus.o_MulClkEn   = !i_Rst;
    assign bus.ov_RspValid  = rRspValid;
    assign bus.ov_RspResult = rRspResult;
    assign bus.ov_RspFlags  = rRspFlags;
    assign bus.o_Idle       = wIdle;
endmodule

// File: doc/fp_mult_arbiter.md
# fp_mult_arbiter

Round-robin arbiter and issue scheduler that shares one fully pipelined floating-point multiplier (fixed latency `pLatency`, one operation per cycle) among `pReq` requesters. It accepts operand pairs through per-requester valid/ready handshakes and issues at most one operation per cycle. A tag delay line tracks which requester owns each in-flight operation, and each result and its exception flags are routed back to that owner. The block sits between the compute clients and the multiplier instance, and drives the multiplier's data-valid and clock-enable inputs.

## Interface
Parameters:
- `pWidth`, 64: floating-point word width (sign+exp+mantissa).
- `pReq`, 4: number of requesters (2..8).
- `pLatency`, 5: multiplier latency in cycles from `o_MulDv` to result valid. Must equal the multiplier's pipeline setting.
- `pMaxOut`, 8: maximum in-flight operations per requester (1..15).

Ports:
- `i_Clk` in 1: clock.
- `i_Rst` in 1: reset, synchronous, active-high.
- `iv_ReqValid` in `pReq`: per-requester request valid.
- `iv_ReqA` in `pReq*pWidth`: packed operand A. Requester k occupies slice `[k*pWidth +: pWidth]`.
- `iv_ReqB` in `pReq*pWidth`: packed operand B, same packing as `iv_ReqA`.
- `ov_ReqReady` out `pReq`: one-hot grant/ready.
- `ov_MulA` out `pWidth`: operand A to multiplier.
- `ov_MulB` out `pWidth`: operand B to multiplier.
- `o_MulDv` out 1: operation valid to multiplier.
- `o_MulClkEn` out 1: multiplier clock enable. Constant 1 outside reset.
- `iv_MulResult` in `pWidth`: multiplier product.
- `i_MulOverflow` in 1: multiplier overflow flag.
- `i_MulUnderflow` in 1: multiplier underflow flag.
- `i_MulNAN` in 1: multiplier NaN flag.
- `ov_RspValid` out `pReq`: one-hot response valid. No backpressure; requesters must accept.
- `ov_RspResult` out `pWidth`: shared response data.
- `ov_RspFlags` out 3: `{NAN, Overflow, Underflow}`.
- `o_Idle` out 1: no operation pending or in flight.

## Operation
- Eligibility: requester k is eligible when `iv_ReqValid[k]` is high and its outstanding count is below `pMaxOut`.
- Grant: combinational round-robin among eligible requesters, searching from pointer `rPtr` upward with modulo `pReq` wrap.
  - `ov_ReqReady` is the one-hot grant, or all-zero when no requester is eligible.
  - Ready never asserts for a requester whose valid is low.
- Pointer update: on an accept to requester k, `rPtr` becomes `(k+1) mod pReq`. With no accept, `rPtr` holds.
- Issue stage (registered): on accept, the issue register captures the operands and tag `{1'b1, k}`. The next cycle drives `ov_MulA`/`ov_MulB` and sets `o_MulDv=1`.
  - With no accept, `o_MulDv=0` and the operands hold their previous values.
- Tag delay line: `pLatency` stages of `{valid, index}`, shifted every cycle. It is fed from the issue register, so the tag exits aligned with the multiplier output.
- Response stage (registered): when the exiting tag is valid with index k, it sets `ov_RspValid[k]=1` and captures `iv_MulResult` and the flags. Otherwise `ov_RspValid=0` and data holds.
- Outstanding counters: one `clog2(pMaxOut+1)`-bit counter per requester.
  - Increment on accept; decrement when the response for that requester is registered.
  - A simultaneous increment and decrement leaves the count unchanged.
  - The counter never exceeds `pMaxOut` and never underflows.
- `o_Idle`: high when all counters are zero and the issue register is invalid.
- Ordering: responses return in issue order. There is at most one accept and one response per cycle.

## Timing
- Reset values:
  - `ov_ReqReady=0`, `o_MulDv=0`, `ov_MulA=0`, `ov_MulB=0`.
  - `o_MulClkEn=0` during reset, 1 from the first cycle after reset.
  - `ov_RspValid=0`, `ov_RspResult=0`, `ov_RspFlags=0`, `o_Idle=1`.
  - `rPtr=0`; all counters and tag stages cleared.
- Latency: accept at edge T gives `o_MulDv` during cycle T+1 and `ov_RspValid` during cycle T+2+`pLatency` (7 cycles at default).
- Throughput: one accept per cycle sustained, including back-to-back accepts from the same requester while it is the only eligible one.
- Counter boundary: a requester at `pMaxOut` whose response is registered in cycle C becomes eligible in cycle C+1, not in C.
- Reset mid-operation: all in-flight tags are discarded. Multiplier outputs arriving after reset produce no `ov_RspValid`.
- A request with valid deasserted before being granted is simply not taken; no state change results.

## Test plan
- Single op: requester 1 sends A=0x4000000000000000 (2.0), B=0x4008000000000000 (3.0) at T. Required: `ov_RspValid=4'b0010` at T+7, `ov_RspResult=0x4018000000000000`, flags 0.
- Contention: all 4 valid in the same cycle, held high. Required: grant order 0,1,2,3,0,…, one per cycle; responses return in the same order, 7 cycles after each accept.
- Fairness: only requesters 0 and 3 continuously valid. Required: grants alternate 0,3,0,3 with no two consecutive grants to the same requester.
- Credit limit: requester 2 alone, valid continuously, `pMaxOut=8`. Required: 8 accepts on consecutive edges, then ready low. Ready re-asserts exactly one cycle after each response, and steady state is 8 in flight.
- Flags routing: requester 3 sends +Inf (0x7FF0000000000000) × 0.0. Required: `ov_RspValid[3]=1` with `ov_RspFlags[2]` (NAN)=1, and no response to any other requester.
- Reset mid-flight: 3 ops accepted, then `i_Rst` for 1 cycle. Required: no `ov_RspValid` for the next 10 cycles, `o_Idle=1`, and the first grant after reset goes to requester 0.
